seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised Moore sequence detector; successor to the fixed 4-bit non-overlapping detector.
- Detects a PAT_W-bit pattern in a serial bit stream qualified by in_valid.
- Overlap or non-overlap matching is selectable at run time.
- Keeps a saturating count of matches for status and debug; sits on the serial input path ahead of framing logic.

Parameters:
- PAT_W, 4, pattern length in bits (legal range 2..16)
- PATTERN, 4'b1101, reset and default pattern, PAT_W bits; MSB is the first bit received
- CNT_W, 8, width of the match counter

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in  input  1  serial data bit
- in_valid  input  1  in is sampled only on edges where in_valid=1
- mode_ovl  input  1  1 = overlapping detection, 0 = non-overlapping
- pat_load  input  1  load pat_in into the pattern register (only with PAT_LOAD_EN)
- pat_in  input  PAT_W  new pattern value
- cnt_clr  input  1  synchronous clear of match_cnt
- out  output  1  Moore match flag
- match_cnt  output  CNT_W  saturating count of matches

Behaviour:
- State registers:
  - hist[PAT_W-1:0]: last received bits; newest bit in bit 0.
  - fill: count of bits valid toward the current window, 0..PAT_W.
  - pat: current pattern.
  - match_q: drives out.
  - match_cnt.
- Reset (rst=0, asynchronous): hist=0, fill=0, pat=PATTERN, match_q=0, out=0, match_cnt=0.
- Valid edge (in_valid=1, no pat_load):
  - hist_n = {hist[PAT_W-2:0], in}; fill_n = min(fill+1, PAT_W).
  - hit = (fill_n==PAT_W) && (hist_n==pat).
  - Registered updates: hist<=hist_n; match_q<=hit.
  - If hit and mode_ovl=0: fill<=0 (the next match must use PAT_W fresh bits). Otherwise fill<=fill_n.
- Idle edge (in_valid=0): hist, fill, match_q and out hold.
  - Moore semantics: out depends only on match_q.
  - out rises on the edge that samples the last pattern bit and stays high until the next valid edge.
- Latency: out is high in the clock cycle after the final pattern bit is presented, i.e. from the edge that samples it.
- match_cnt:
  - Increments by 1 on each edge where hit=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_clr=1 forces 0 on that edge; cnt_clr takes priority over a simultaneous hit.
- mode_ovl is sampled on every valid edge. Changing it mid-stream affects only the fill update on the next hit; it never retroactively creates or suppresses a match.
- Reset asserted mid-sequence clears all state immediately. The first match after reset needs PAT_W new valid bits.
- Non-overlap after a hit: hist keeps its bits, but they cannot contribute to a match because fill=0.

Optional Feature:
- Macro: SEQ_DETECT_PAT_LOAD_EN.
- Defined:
  - pat_load=1 on an edge loads pat<=pat_in, sets fill<=0 and match_q<=0.
  - On that edge, in/in_valid are ignored and match_cnt is unchanged (cnt_clr still applies).
  - The pattern persists until the next load or reset.
- Undefined:
  - pat is constant PATTERN.
  - pat_load and pat_in remain on the port list but are ignored; no pattern register is synthesised.

Test Plan:
1. Reset, mode_ovl=0, valid stream 0,1,0,1,1,0,1,0,1,1,0,1,0,1 -> out pulses after bit index 6 and after index 11; match_cnt=2.
2. mode_ovl=1, stream 1,1,0,1,1,0,1 -> out high after index 3 and index 6, match_cnt=2. Same stream with mode_ovl=0 -> only the index-3 match, match_cnt=1.
3. After the last 1101 bit, hold in_valid=0 for 5 cycles -> out stays 1. Next valid bit 0 -> out=0. Drop rst mid-pattern (after 1,1,0) -> out=0 and match_cnt=0 immediately; then 1 alone gives no match.
4. CNT_W=2, overlap mode, stream 1,1,1,1,1,1,1 with pattern 1111 -> 4 hits; match_cnt reads 1,2,3,3 (saturates). cnt_clr coincident with a hit -> match_cnt=0.
5. (SEQ_DETECT_PAT_LOAD_EN defined) Load pat_in=4'b0110 with in_valid=1 on the same edge -> that bit ignored, fill=0. Then stream 0,1,1,0 -> out=1. Stream 1,1,0,1 -> no match.
6. PAT_W=8, PATTERN=8'hA5, stream 0xA5 MSB-first preceded by 3 random bits -> single out pulse after the 8th pattern bit; no pulse earlier.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised Moore sequence detector on a serial bit stream.
// Detects a PAT_W-bit pattern (MSB received first) among bits qualified by
// in_valid. Overlapping or non-overlapping matching is chosen at run time.
// A saturating match counter is kept for status and debug.
//
// Optional feature (macro SEQ_DETECT_PAT_LOAD_EN): the pattern becomes a
// run-time loadable register driven by pat_load/pat_in. When the macro is
// undefined the pattern is the constant PATTERN, and pat_load/pat_in are ignored.
//
// Input qualification: in is consumed only on rising edges where in_valid=1.
// Idle edges leave the window and the out flag unchanged.
module seq_detect_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             mode_ovl,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              match_q, match_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [PAT_W-1:0]  pat;
  logic              load;
  logic [PAT_W-1:0]  hist_n;
  logic [FILL_W-1:0] fill_n;
  logic              hit;

`ifdef SEQ_DETECT_PAT_LOAD_EN
  logic [PAT_W-1:0] pat_q;

  // Pattern register: reloaded by pat_load, persists until the next load or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= PATTERN;
    end else if (pat_load) begin
      pat_q <= pat_in;
    end
  end

  assign pat  = pat_q;
  assign load = pat_load;
`else
  // Fixed pattern build: the load inputs stay on the port list but do nothing.
  logic unused_pat_load;
  assign unused_pat_load = ^{pat_load, pat_in};
  assign pat  = PATTERN;
  assign load = 1'b0;
`endif

  // Candidate window, fill level and match decision for the current edge.
  always_comb begin
    hist_n = {hist_q[PAT_W-2:0], in};
    fill_n = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FILL_W'(1);
    hit    = in_valid && !load && (fill_n == FILL_MAX) && (hist_n == pat);
  end

  // Next-state for the window, fill counter and Moore match flag.
  // A non-overlapping hit empties the fill so the next match needs fresh bits.
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = match_q;
    if (load) begin
      fill_d  = '0;
      match_d = 1'b0;
    end else if (in_valid) begin
      hist_d  = hist_n;
      match_d = hit;
      fill_d  = (hit && !mode_ovl) ? '0 : fill_n;
    end
  end

  // Saturating match counter; a clear wins over a coincident hit.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers, all cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out       = match_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: scoreboard bench for seq_detect_param (default build).
// The reference model keeps the list of bits that may still take part in a
// match and compares its last PAT_W entries against the pattern.
module tb_seq_detect_param;

  localparam int               PAT_W   = 4;
  localparam logic [PAT_W-1:0] PATTERN = 4'b1101;
  localparam int               CNT_W   = 8;
  localparam int               CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             din = 1'b0;
  logic             din_valid = 1'b0;
  logic             mode_ovl = 1'b0;
  logic             pat_load = 1'b0;
  logic [PAT_W-1:0] pat_in = '0;
  logic             cnt_clr = 1'b0;
  logic             dout;
  logic [CNT_W-1:0] match_cnt;

  always #5 clk = ~clk;

  seq_detect_param #(
    .PAT_W  (PAT_W),
    .PATTERN(PATTERN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (din),
    .in_valid (din_valid),
    .mode_ovl (mode_ovl),
    .pat_load (pat_load),
    .pat_in   (pat_in),
    .cnt_clr  (cnt_clr),
    .out      (dout),
    .match_cnt(match_cnt)
  );

  // ---------------- reference model ----------------
  bit               mdl_bits[$];
  logic             mdl_out = 1'b0;
  int               mdl_cnt = 0;
  logic [PAT_W-1:0] pat_ref = PATTERN;

  function automatic bit window_matches();
    if (mdl_bits.size() != PAT_W) return 1'b0;
    for (int i = 0; i < PAT_W; i++) begin
      if (mdl_bits[i] != pat_ref[PAT_W-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    mdl_bits.delete();
    mdl_out = 1'b0;
    mdl_cnt = 0;
  endtask

  // ---------------- scoreboard ----------------
  logic [CNT_W:0] exp_q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic check_val(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Monitor: one expected {out, match_cnt} per driven edge, compared mid-cycle.
  initial begin
    logic [CNT_W:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_val("sb_out", int'(dout), int'(e[CNT_W]));
        check_val("sb_cnt", int'(match_cnt), int'(e[CNT_W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic b, input logic v, input logic o, input logic c);
    bit h;
    din = b; din_valid = v; mode_ovl = o; cnt_clr = c;
    @(posedge clk);
    h = 1'b0;
    if (v) begin
      mdl_bits.push_back(b);
      if (mdl_bits.size() > PAT_W) void'(mdl_bits.pop_front());
      h = window_matches();
      if (h && !o) mdl_bits.delete();
      mdl_out = h;
    end
    if (c) mdl_cnt = 0;
    else if (h && mdl_cnt < CNT_MAX) mdl_cnt++;
    exp_q.push_back({mdl_out, CNT_W'(mdl_cnt)});
    #1;
    din_valid = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic feed(input logic [31:0] bits, input int n, input logic o);
    logic [31:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) step(v[i], 1'b1, o, 1'b0);
  endtask

  // Async reset: wait for the scoreboard to drain, then pull reset mid-cycle.
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    check_val("rst_out", int'(dout), 0);
    check_val("rst_cnt", int'(match_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2;
    check_val("init_out", int'(dout), 0);
    check_val("init_cnt", int'(match_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    #1;

    // Non-overlap stream: matches at indices 6 and 11.
    feed(32'b01011010110101, 14, 1'b0);
    settle();
    check_val("t1_cnt", int'(match_cnt), 2);

    // Overlap vs non-overlap on 1,1,0,1,1,0,1.
    do_reset();
    feed(32'b1101101, 7, 1'b1);
    settle();
    check_val("t2_ovl_cnt", int'(match_cnt), 2);
    do_reset();
    feed(32'b1101101, 7, 1'b0);
    settle();
    check_val("t2_novl_cnt", int'(match_cnt), 1);

    // Out holds across idle cycles, drops on the next valid bit.
    do_reset();
    feed(32'b1101, 4, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    check_val("t3_hold_out", int'(dout), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    check_val("t3_drop_out", int'(dout), 0);

    // Reset mid-pattern, then a lone 1 must not match.
    feed(32'b110, 3, 1'b0);
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    settle();
    check_val("t3_after_rst_out", int'(dout), 0);

    // Saturation in overlap mode (one hit per 3 bits), then clear on a hit.
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (270) feed(32'b101, 3, 1'b1);
    settle();
    check_val("sat_cnt", int'(match_cnt), CNT_MAX);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    check_val("clr_hit_out", int'(dout), 1);
    check_val("clr_hit_cnt", int'(match_cnt), 0);

    // Randomised traffic with mode changes and occasional clears.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0),
           (i % 80) < 40 ? 1'b1 : 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 49) == 0));
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
